fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//   Upstream feeder for the accumulator in the FIR datapath. Takes one input sample per frame
//   over a valid/ready handshake and stores it in a circular delay line. It then issues NTAPS
//   signed products coef[k]*x[n-k], one per cycle, and drives the accumulator's in/load/en/abs
//   controls. A one-cycle frame_done strobe marks the cycle in which the accumulator output holds
//   the completed dot product.
// PARAMETERS
//   WIDTH      16  sample and coefficient width, signed two's complement
//   NTAPS      8   filter length; also the delay-line depth (>=2)
//   ACC_WIDTH  32  product width presented to the accumulator; must be >= 2*WIDTH
// PORTS
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high; clears all state
//   in_valid   in   1          in_sample is valid
//   in_ready   out  1          block can accept a sample this cycle
//   in_sample  in   WIDTH      signed input sample x[n]
//   abs_mode   in   1          sampled at the handshake; drives acc_abs for the whole frame
//   coef_we    in   1          coefficient write strobe
//   coef_addr  in   log2(NTAPS) tap index to write
//   coef_data  in   WIDTH      signed coefficient value
//   acc_in     out  ACC_WIDTH  sign-extended product to the accumulator
//   acc_load   out  1          first tap of a frame; the accumulator loads acc_in
//   acc_en     out  1          acc_in is valid; the accumulator adds or loads it
//   acc_abs    out  1          abs control for the accumulator
//   frame_done out  1          1-cycle strobe; the accumulator output holds y[n]
// BEHAVIOUR
//   - Reset (async): state=IDLE. acc_in, acc_load, acc_en, acc_abs and frame_done = 0.
//     in_ready=0 while reset is high. Delay line, coefficient RAM, wr_ptr and tap counter = 0.
//   - in_ready = (state==IDLE) & ~reset. A sample is accepted on a clock edge where
//     in_valid & in_ready are both high.
//   - FSM transitions:
//     - IDLE -> RUN on accept.
//     - RUN -> DONE after issuing tap NTAPS-1.
//     - DONE -> IDLE unconditionally after 1 cycle.
//   - Accept edge actions: write x into line[wr_ptr]; base=wr_ptr; wr_ptr=(wr_ptr+1) mod NTAPS;
//     k=0; latch abs_mode into acc_abs.
//   - RUN cycle k (k=0..NTAPS-1): outputs are registered.
//     - acc_in = sext(coef[k] * line[(base-k) mod NTAPS]), full 2*WIDTH signed product
//       sign-extended to ACC_WIDTH; no truncation and no saturation.
//     - acc_en=1. acc_load=1 only for k=0.
//     - The first product appears in the cycle after the accept edge.
//   - DONE cycle: frame_done=1; acc_en=0, acc_load=0. acc_abs holds until the next accept.
//   - Frame period is NTAPS+2 cycles (IDLE, NTAPS x RUN, DONE). The next sample can be accepted
//     at the earliest on the first IDLE edge after DONE.
//   - in_valid during RUN or DONE is not accepted. The source holds in_sample until in_ready.
//   - coef_we acts only in IDLE and takes effect for the next frame.
//     coef_we in RUN or DONE is ignored; the coefficient RAM is unchanged.
//   - Simultaneous coef_we and sample accept in IDLE: the write lands first, so the new
//     coefficient is used in that frame.
//   - Delay-line wrap: the oldest sample is overwritten once more than NTAPS samples have
//     been accepted. Before NTAPS samples, unfilled entries read 0.
//   - Reset mid-frame: all outputs drop to 0 asynchronously. No frame_done is issued for the
//     aborted frame, and the delay line is cleared.
// TESTING  (bench: WIDTH=16, NTAPS=4, ACC_WIDTH=32, accumulator instantiated downstream)
//   1. Assert reset, release -> all outputs 0; in_ready=1 on the first cycle after release.
//   2. coef=[1,2,3,4], push 5 -> acc_in 5,0,0,0 with load on the first; frame_done one cycle
//      later; accumulator out=5. Push 7 -> acc_in 7,10,0,0; accumulator out=0x11.
//   3. coef0=16'hFFFF (-1), push 3 -> acc_in=32'hFFFFFFFD. With abs_mode=1 -> acc_abs=1 for
//      the frame and accumulator out=3.
//   4. coef=[1,1,1,1], push 1..5 -> the 5th frame products are 5,4,3,2 (wrap);
//      accumulator out=0xE.
//   5. Hold in_valid through RUN -> in_ready=0 and no accept until IDLE; accepts spaced
//      exactly 6 cycles apart. coef_we during RUN -> next frame uses the old coefficient.
//   6. Assert reset during tap 2 -> acc_en, acc_load and frame_done drop to 0 immediately.
//      After release, push 9 with coef=[1,1,1,1] -> accumulator out=9 (line cleared).

Source files
------------

// File: rtl/fir_tap_sequencer_if.sv
// ============================================================================
// Module  : fir_tap_sequencer_if
// Brief   : Sample handshake, coefficient write port and accumulator controls.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fir_tap_sequencer_if #(
  parameter int WIDTH     = 16,
  parameter int NTAPS     = 8,
  parameter int ACC_WIDTH = 32
);
  localparam int C_AW = $clog2(NTAPS);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_sample;
  logic                 abs_mode;
  logic                 coef_we;
  logic [C_AW-1:0]      coef_addr;
  logic [WIDTH-1:0]     coef_data;
  logic [ACC_WIDTH-1:0] acc_in;
  logic                 acc_load;
  logic                 acc_en;
  logic                 acc_abs;
  logic                 frame_done;

  modport master (
    output in_valid, in_sample, abs_mode, coef_we, coef_addr, coef_data,
    input  in_ready, acc_in, acc_load, acc_en, acc_abs, frame_done
  );

  modport slave (
    input  in_valid, in_sample, abs_mode, coef_we, coef_addr, coef_data,
    output in_ready, acc_in, acc_load, acc_en, acc_abs, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
// ============================================================================
// Module  : fir_tap_sequencer
// Brief   : Circular delay line + coefficient RAM issuing one product per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_tap_sequencer #(
  parameter int WIDTH     = 16,
  parameter int NTAPS     = 8,
  parameter int ACC_WIDTH = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fir_tap_sequencer_if.slave bus
);
  localparam int              C_AW    = $clog2(NTAPS);
  localparam logic [C_AW-1:0] C_LAST  = C_AW'(NTAPS - 1);
  localparam logic [C_AW:0]   C_DEPTH = (C_AW + 1)'(NTAPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [WIDTH-1:0] r_line [NTAPS];
  logic signed [WIDTH-1:0] r_coef [NTAPS];
  logic [C_AW-1:0]         r_wr_ptr;
  logic [C_AW-1:0]         r_base;
  logic [C_AW-1:0]         r_tap;
  logic [ACC_WIDTH-1:0]    r_acc_in;
  logic                    r_acc_load;
  logic                    r_acc_en;
  logic                    r_acc_abs;
  logic                    r_frame_done;

  logic                      w_accept;
  logic [C_AW-1:0]           w_next_tap;
  logic [C_AW-1:0]           w_rd_idx;
  logic signed [WIDTH-1:0]   w_mul_x;
  logic signed [WIDTH-1:0]   w_mul_c;
  logic signed [2*WIDTH-1:0] w_prod;

  assign bus.in_ready = (r_state == S_IDLE) & ~reset;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_next_tap   = r_tap + C_AW'(1);

  // (base - k) mod NTAPS, valid for any NTAPS, not only powers of two
  assign w_rd_idx = (r_base >= w_next_tap) ? (r_base - w_next_tap)
                  : C_AW'({1'b0, r_base} + C_DEPTH - {1'b0, w_next_tap});

  // Tap 0 is computed on the accept edge, so it takes the incoming sample and
  // any coefficient being written in the same cycle.
  always_comb begin
    w_mul_x = r_line[w_rd_idx];
    w_mul_c = r_coef[w_next_tap];
    if (r_state == S_IDLE) begin
      w_mul_x = bus.in_sample;
      w_mul_c = (bus.coef_we && (bus.coef_addr == '0)) ? bus.coef_data : r_coef[0];
    end
  end

  assign w_prod = w_mul_x * w_mul_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_base       <= '0;
      r_tap        <= '0;
      r_acc_in     <= '0;
      r_acc_load   <= 1'b0;
      r_acc_en     <= 1'b0;
      r_acc_abs    <= 1'b0;
      r_frame_done <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        r_line[i] <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      if ((r_state == S_IDLE) && bus.coef_we) begin
        r_coef[bus.coef_addr] <= bus.coef_data;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_line[r_wr_ptr] <= bus.in_sample;
            r_base           <= r_wr_ptr;
            r_wr_ptr         <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + C_AW'(1);
            r_tap            <= '0;
            r_acc_abs        <= bus.abs_mode;
            r_acc_in         <= ACC_WIDTH'(w_prod);
            r_acc_en         <= 1'b1;
            r_acc_load       <= 1'b1;
            r_state          <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc_load <= 1'b0;
          if (r_tap == C_LAST) begin
            r_acc_en     <= 1'b0;
            r_acc_in     <= '0;
            r_frame_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_tap    <= w_next_tap;
            r_acc_in <= ACC_WIDTH'(w_prod);
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.acc_in     = r_acc_in;
  assign bus.acc_load   = r_acc_load;
  assign bus.acc_en     = r_acc_en;
  assign bus.acc_abs    = r_acc_abs;
  assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
// ============================================================================
// Module  : tb_fir_tap_sequencer
// Brief   : Directed bench for fir_tap_sequencer with a downstream accumulator model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_tap_sequencer;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fir_tap_sequencer_if #(.WIDTH(16), .NTAPS(4), .ACC_WIDTH(32)) bus ();

  fir_tap_sequencer #(.WIDTH(16), .NTAPS(4), .ACC_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Downstream accumulator: load on acc_load, add otherwise, abs on the output.
  logic [31:0] acc_q;
  always @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else if (bus.acc_en) acc_q <= bus.acc_load ? bus.acc_in : acc_q + bus.acc_in;
  end
  wire [31:0] acc_out = (bus.acc_abs && acc_q[31]) ? (~acc_q + 32'd1) : acc_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wcoef(input logic [1:0] addr, input logic [15:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = addr;
    bus.coef_data = data;
    @(negedge clk);
    bus.coef_we   = 1'b0;
  endtask

  task automatic set4(input logic [15:0] c0, c1, c2, c3);
    wcoef(2'd0, c0);
    wcoef(2'd1, c1);
    wcoef(2'd2, c2);
    wcoef(2'd3, c3);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after DONE.
  task automatic frame(input string name, input logic [15:0] x, input logic a,
                       input logic [31:0] p0, p1, p2, p3, input logic [31:0] y);
    logic [31:0] ep [4];
    int waited;
    ep = '{p0, p1, p2, p3};
    bus.in_valid  = 1'b1;
    bus.in_sample = x;
    bus.abs_mode  = a;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk1({name, "_ready"}, bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.abs_mode = 1'b0;
    bus.coef_we  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_tap%0d_in", name, k), bus.acc_in, ep[k]);
      chk1($sformatf("%s_tap%0d_en", name, k), bus.acc_en, 1'b1);
      chk1($sformatf("%s_tap%0d_load", name, k), bus.acc_load, (k == 0));
      chk1($sformatf("%s_tap%0d_abs", name, k), bus.acc_abs, a);
      chk1($sformatf("%s_tap%0d_done", name, k), bus.frame_done, 1'b0);
      @(negedge clk);
    end
    chk1({name, "_done"}, bus.frame_done, 1'b1);
    chk1({name, "_done_en"}, bus.acc_en, 1'b0);
    chk1({name, "_done_abs"}, bus.acc_abs, a);
    chk({name, "_y"}, acc_out, y);
    @(negedge clk);
    chk1({name, "_idle_done"}, bus.frame_done, 1'b0);
    chk1({name, "_idle_ready"}, bus.in_ready, 1'b1);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    #1;
    chk1({name, "_rst_ready"}, bus.in_ready, 1'b0);
    chk1({name, "_rst_en"}, bus.acc_en, 1'b0);
    chk1({name, "_rst_done"}, bus.frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.abs_mode  = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk1("rst_ready", bus.in_ready, 1'b0);
    chk("rst_acc_in", bus.acc_in, 32'd0);
    chk1("rst_load", bus.acc_load, 1'b0);
    chk1("rst_en", bus.acc_en, 1'b0);
    chk1("rst_abs", bus.acc_abs, 1'b0);
    chk1("rst_done", bus.frame_done, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rel_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    chk1("rel_ready_cycle1", bus.in_ready, 1'b1);
    chk1("rel_en", bus.acc_en, 1'b0);

    // Basic dot products
    set4(16'd1, 16'd2, 16'd3, 16'd4);
    frame("t2a", 16'd5, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5);
    frame("t2b", 16'd7, 1'b0, 32'd7, 32'd10, 32'd0, 32'd0, 32'h11);

    // Negative coefficient, abs mode, coefficient write coincident with accept
    set4(16'hFFFF, 16'd0, 16'd0, 16'd0);
    frame("t3a", 16'd3, 1'b0, 32'hFFFFFFFD, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFD);
    frame("t3b", 16'd3, 1'b1, 32'hFFFFFFFD, 32'd0, 32'd0, 32'd0, 32'd3);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'd0;
    bus.coef_data = 16'd2;
    frame("t3c", 16'd4, 1'b0, 32'd8, 32'd0, 32'd0, 32'd0, 32'd8);

    // Delay-line fill and wrap from a cleared line
    do_reset("t4");
    set4(16'd1, 16'd1, 16'd1, 16'd1);
    frame("t4_1", 16'd1, 1'b0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1);
    frame("t4_2", 16'd2, 1'b0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3);
    frame("t4_3", 16'd3, 1'b0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd6);
    frame("t4_4", 16'd4, 1'b0, 32'd4, 32'd3, 32'd2, 32'd1, 32'd10);
    frame("t4_5", 16'd5, 1'b0, 32'd5, 32'd4, 32'd3, 32'd2, 32'hE);

    // in_valid held through RUN/DONE; coef write during RUN must be ignored
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'd6;
    for (int i = 0; i < 12; i++) begin
      chk1($sformatf("t5_ready%0d", i), bus.in_ready, (i == 0 || i == 6));
      chk1($sformatf("t5_done%0d", i), bus.frame_done, (i == 5 || i == 11));
      if (i == 2) begin
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'd0;
        bus.coef_data = 16'd5;
      end
      if (i == 3) bus.coef_we = 1'b0;
      if (i == 5) chk("t5_y0", acc_out, 32'd18);
      if (i == 7) begin
        chk("t5_f2_tap0", bus.acc_in, 32'd6);
        bus.in_valid = 1'b0;
      end
      if (i == 11) chk("t5_y1", acc_out, 32'd21);
      @(negedge clk);
    end
    chk1("t5_idle_ready", bus.in_ready, 1'b1);

    // Reset during tap 2 aborts the frame and clears the line
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'd8;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk1("t6_tap0_load", bus.acc_load, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk1("t6_tap2_en", bus.acc_en, 1'b1);
    reset = 1'b1;
    #1;
    chk1("t6_rst_en", bus.acc_en, 1'b0);
    chk1("t6_rst_load", bus.acc_load, 1'b0);
    chk1("t6_rst_done", bus.frame_done, 1'b0);
    chk("t6_rst_acc_in", bus.acc_in, 32'd0);
    chk1("t6_rst_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk1($sformatf("t6_no_done%0d", i), bus.frame_done, 1'b0);
      @(negedge clk);
    end
    set4(16'd1, 16'd1, 16'd1, 16'd1);
    frame("t6", 16'd9, 1'b0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
